// File: rtl/bp_train_unit.sv
// Retire-side branch training unit: classifies resolved branches, queues training
// records in an in-order FIFO, and strobes recovery on the oldest mispredict.
// Optional perf counters are enabled with `define BP_TRAIN_PERF_EN.

module bp_train_slot (
  input  logic        valid_i,
  input  logic        pred_taken_i,
  input  logic        actual_taken_i,
  input  logic [31:0] pred_target_i,
  input  logic [31:0] actual_target_i,
  output logic        mispred_o
);
  assign mispred_o = valid_i &&
                     ((pred_taken_i != actual_taken_i) ||
                      (actual_taken_i && pred_taken_i && (pred_target_i != actual_target_i)));
endmodule

module bp_train_unit #(
  parameter int GH       = 8,
  parameter int RETIRE_W = 2,
  parameter int DEPTH    = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [RETIRE_W-1:0]    retire_valid_i,
  input  logic [RETIRE_W*32-1:0] retire_pc_i,
  input  logic [RETIRE_W-1:0]    retire_actual_taken_i,
  input  logic [RETIRE_W*32-1:0] retire_actual_target_i,
  input  logic [RETIRE_W-1:0]    retire_pred_taken_i,
  input  logic [RETIRE_W*32-1:0] retire_pred_target_i,
  input  logic [RETIRE_W*GH-1:0] retire_ghr_snapshot_i,
  output logic                   retire_ready_o,
  output logic                   train_valid_o,
  output logic [31:0]            train_pc_o,
  output logic                   train_actual_taken_o,
  output logic [31:0]            train_actual_target_o,
  output logic [GH-1:0]          train_ghr_snapshot_o,
  output logic                   recover_mispredict_pulse_o,
  output logic [GH-1:0]          recover_ghr_snapshot_o
`ifdef BP_TRAIN_PERF_EN
  ,
  output logic [31:0]            perf_branch_count_o,
  output logic [31:0]            perf_mispredict_count_o
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][31:0]   pc_q, tgt_q;
  logic [DEPTH-1:0]         tkn_q;
  logic [DEPTH-1:0][GH-1:0] ghr_q;
  logic [PW-1:0]            head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     recover_pulse_q, recover_pulse_d;
  logic [GH-1:0]            recover_ghr_q;

  logic [RETIRE_W-1:0]          misp, acc, acc_misp;
  logic [RETIRE_W-1:0][PW-1:0]  wr_idx;
  logic [CW-1:0]                n_enq;
  logic                         enq_en, pop, rec_hit;
  logic [GH-1:0]                rec_ghr;

  for (genvar k = 0; k < RETIRE_W; k++) begin : g_slot
    bp_train_slot u_slot (
      .valid_i        (retire_valid_i[k]),
      .pred_taken_i   (retire_pred_taken_i[k]),
      .actual_taken_i (retire_actual_taken_i[k]),
      .pred_target_i  (retire_pred_target_i[32*k +: 32]),
      .actual_target_i(retire_actual_target_i[32*k +: 32]),
      .mispred_o      (misp[k])
    );
  end

  // A slot-0 mispredict squashes every younger slot; write slots are packed in order.
  always_comb begin
    acc = retire_valid_i;
    for (int k = 1; k < RETIRE_W; k++) acc[k] = retire_valid_i[k] & ~misp[0];
    acc_misp = acc & misp;
    n_enq    = '0;
    rec_hit  = 1'b0;
    rec_ghr  = '0;
    for (int k = 0; k < RETIRE_W; k++) begin
      wr_idx[k] = tail_q + n_enq[PW-1:0];
      if (acc[k]) n_enq = n_enq + 1'b1;
      if (acc_misp[k] && !rec_hit) begin
        rec_hit = 1'b1;
        rec_ghr = {retire_ghr_snapshot_i[k*GH +: GH-1], retire_actual_taken_i[k]};
      end
    end
  end

  assign retire_ready_o  = (count_q <= CW'(DEPTH - RETIRE_W));
  assign enq_en          = retire_ready_o;
  assign pop             = (count_q != '0);
  assign head_d          = head_q + PW'(pop);
  assign tail_d          = tail_q + (enq_en ? n_enq[PW-1:0] : '0);
  assign count_d         = count_q + (enq_en ? n_enq : '0) - CW'(pop);
  assign recover_pulse_d = enq_en & rec_hit;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q            <= '0;
      tgt_q           <= '0;
      tkn_q           <= '0;
      ghr_q           <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      recover_pulse_q <= 1'b0;
      recover_ghr_q   <= '0;
    end else begin
      if (enq_en) begin
        for (int k = 0; k < RETIRE_W; k++) begin
          if (acc[k]) begin
            pc_q[wr_idx[k]]  <= retire_pc_i[32*k +: 32];
            tgt_q[wr_idx[k]] <= retire_actual_target_i[32*k +: 32];
            tkn_q[wr_idx[k]] <= retire_actual_taken_i[k];
            ghr_q[wr_idx[k]] <= retire_ghr_snapshot_i[GH*k +: GH];
          end
        end
      end
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      recover_pulse_q <= recover_pulse_d;
      if (recover_pulse_d) recover_ghr_q <= rec_ghr;
    end
  end

  assign train_valid_o              = pop;
  assign train_pc_o                 = pc_q[head_q];
  assign train_actual_taken_o       = tkn_q[head_q];
  assign train_actual_target_o      = tgt_q[head_q];
  assign train_ghr_snapshot_o       = ghr_q[head_q];
  assign recover_mispredict_pulse_o = recover_pulse_q;
  assign recover_ghr_snapshot_o     = recover_ghr_q;

`ifdef BP_TRAIN_PERF_EN
  logic [31:0] perf_br_q, perf_mp_q;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_br_q <= '0;
      perf_mp_q <= '0;
    end else if (enq_en) begin
      perf_br_q <= perf_br_q + 32'($countones(acc));
      perf_mp_q <= perf_mp_q + 32'($countones(acc_misp));
    end
  end
  assign perf_branch_count_o     = perf_br_q;
  assign perf_mispredict_count_o = perf_mp_q;
`endif

  // Retiring while not ready loses records; flag it loudly in simulation.
  always @(posedge clock) begin
    if (reset && !retire_ready_o)
      assert (retire_valid_i == '0) else $error("bp_train_unit: retire while not ready");
  end
endmodule

// File: tb/tb_bp_train_unit.sv
// Scoreboard bench for bp_train_unit: random and directed retire traffic checked
// against a queue-based reference model of the training FIFO and recovery strobe.
module tb_bp_train_unit;
  localparam int GH = 8, RW = 2, DEPTH = 8;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [RW-1:0]    retire_valid_i = '0, retire_actual_taken_i = '0, retire_pred_taken_i = '0;
  logic [RW*32-1:0] retire_pc_i = '0, retire_actual_target_i = '0, retire_pred_target_i = '0;
  logic [RW*GH-1:0] retire_ghr_snapshot_i = '0;
  logic            retire_ready_o, train_valid_o, train_actual_taken_o, recover_mispredict_pulse_o;
  logic [31:0]     train_pc_o, train_actual_target_o;
  logic [GH-1:0]   train_ghr_snapshot_o, recover_ghr_snapshot_o;

  bp_train_unit #(.GH(GH), .RETIRE_W(RW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .retire_valid_i(retire_valid_i), .retire_pc_i(retire_pc_i),
    .retire_actual_taken_i(retire_actual_taken_i), .retire_actual_target_i(retire_actual_target_i),
    .retire_pred_taken_i(retire_pred_taken_i), .retire_pred_target_i(retire_pred_target_i),
    .retire_ghr_snapshot_i(retire_ghr_snapshot_i), .retire_ready_o(retire_ready_o),
    .train_valid_o(train_valid_o), .train_pc_o(train_pc_o),
    .train_actual_taken_o(train_actual_taken_o), .train_actual_target_o(train_actual_target_o),
    .train_ghr_snapshot_o(train_ghr_snapshot_o),
    .recover_mispredict_pulse_o(recover_mispredict_pulse_o),
    .recover_ghr_snapshot_o(recover_ghr_snapshot_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit v; bit [31:0] pc; bit at; bit [31:0] atgt; bit pt; bit [31:0] ptgt; bit [7:0] ghr;
  } slot_t;
  typedef struct { int tag; bit [31:0] pc; bit t; bit [31:0] tgt; bit [7:0] ghr; } rec_t;
  typedef struct { int tag; bit [7:0] ghr; } rcv_t;

  rec_t tq[$];
  rcv_t rq[$];
  bit [7:0] exp_rghr = '0;
  int cyc = 0, n_cmp = 0, n_err = 0;

  always @(posedge clock) cyc++;

  function automatic int fifo_cnt();
    int c = 0;
    foreach (tq[i]) if (tq[i].tag <= cyc) c++;
    return c;
  endfunction

  function automatic bit model_ready();
    return (DEPTH - fifo_cnt()) >= RW;
  endfunction

  function automatic bit is_misp(slot_t s);
    return s.v && ((s.pt != s.at) || (s.at && s.pt && s.ptgt != s.atgt));
  endfunction

  task automatic check(string name, bit ok, logic [63:0] act, logic [63:0] req);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compares every DUT output cycle against the model, mid-cycle.
  always @(negedge clock) begin
    if (reset) begin
      int c;
      bit due;
      c = fifo_cnt();
      check("ready", retire_ready_o == ((DEPTH - c) >= RW), 64'(retire_ready_o), 64'((DEPTH - c) >= RW));
      check("train_valid", train_valid_o == (c > 0), 64'(train_valid_o), 64'(c > 0));
      if (c > 0) begin
        rec_t r;
        r = tq.pop_front();
        check("train_rec",
              train_pc_o == r.pc && train_actual_taken_o == r.t &&
              train_actual_target_o == r.tgt && train_ghr_snapshot_o == r.ghr,
              {train_pc_o, 23'd0, train_actual_taken_o, train_ghr_snapshot_o},
              {r.pc, 23'd0, r.t, r.ghr});
      end
      due = (rq.size() > 0) && (rq[0].tag == cyc);
      check("recover_pulse", recover_mispredict_pulse_o == due,
            64'(recover_mispredict_pulse_o), 64'(due));
      if (due) exp_rghr = rq.pop_front().ghr;
      check("recover_ghr", recover_ghr_snapshot_o == exp_rghr,
            64'(recover_ghr_snapshot_o), 64'(exp_rghr));
    end
  end

  task automatic drive_idle();
    retire_valid_i = '0;
    @(posedge clock); #1;
  endtask

  // Called at posedge+1; waits for model ready, drives one retire cycle, updates the model.
  task automatic issue(slot_t s0, slot_t s1);
    slot_t s[2];
    bit m0;
    int guard = 0;
    while (!model_ready()) begin
      drive_idle();
      if (++guard > 50) begin
        check("ready_timeout", 1'b0, 0, 1);
        return;
      end
    end
    s[0] = s0; s[1] = s1;
    for (int k = 0; k < RW; k++) begin
      retire_valid_i[k]               = s[k].v;
      retire_pc_i[32*k +: 32]         = s[k].pc;
      retire_actual_taken_i[k]        = s[k].at;
      retire_actual_target_i[32*k +: 32] = s[k].atgt;
      retire_pred_taken_i[k]          = s[k].pt;
      retire_pred_target_i[32*k +: 32] = s[k].ptgt;
      retire_ghr_snapshot_i[GH*k +: GH] = s[k].ghr;
    end
    m0 = is_misp(s0);
    if (s0.v) tq.push_back('{cyc + 1, s0.pc, s0.at, s0.atgt, s0.ghr});
    if (s1.v && !m0) tq.push_back('{cyc + 1, s1.pc, s1.at, s1.atgt, s1.ghr});
    if (m0) rq.push_back('{cyc + 1, {s0.ghr[6:0], s0.at}});
    else if (is_misp(s1)) rq.push_back('{cyc + 1, {s1.ghr[6:0], s1.at}});
    @(posedge clock); #1;
    retire_valid_i = '0;
  endtask

  function automatic slot_t mk(bit v, bit [31:0] pc, bit pt, bit at, bit [31:0] ptgt,
                               bit [31:0] atgt, bit [7:0] ghr);
    slot_t s;
    s.v = v; s.pc = pc; s.pt = pt; s.at = at; s.ptgt = ptgt; s.atgt = atgt; s.ghr = ghr;
    return s;
  endfunction

  function automatic slot_t rnd_slot();
    slot_t s;
    s.v    = ($urandom_range(0, 3) != 0);
    s.pc   = {$urandom_range(0, 65535), 2'b00};
    s.at   = $urandom_range(0, 1);
    s.pt   = ($urandom_range(0, 4) == 0) ? ~s.at : s.at;
    s.atgt = {$urandom_range(0, 255), 2'b00};
    s.ptgt = ($urandom_range(0, 4) == 0) ? s.atgt + 32'd4 : s.atgt;
    s.ghr  = 8'($urandom_range(0, 255));
    return s;
  endfunction

  slot_t nil;

  initial begin
    nil = mk(0, 0, 0, 0, 0, 0, 0);
    #3;
    check("rst_train_valid", train_valid_o == 1'b0, 64'(train_valid_o), 0);
    check("rst_train_data", {train_pc_o, train_actual_target_o, train_actual_taken_o, train_ghr_snapshot_o} == '0,
          {train_pc_o, train_actual_target_o}, 0);
    check("rst_recover", {recover_mispredict_pulse_o, recover_ghr_snapshot_o} == '0,
          64'({recover_mispredict_pulse_o, recover_ghr_snapshot_o}), 0);
    check("rst_ready", retire_ready_o == 1'b1, 64'(retire_ready_o), 1);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    drive_idle();

    // Directed cases.
    issue(mk(1, 32'h100, 1, 1, 32'h200, 32'h200, 8'h5A), nil);
    drive_idle(); drive_idle();
    issue(mk(1, 32'h110, 0, 1, 32'h300, 32'h300, 8'h81), nil);
    drive_idle(); drive_idle();
    issue(mk(1, 32'h120, 1, 1, 32'h10, 32'h10, 8'h11), mk(1, 32'h124, 1, 1, 32'h40, 32'h44, 8'hFF));
    drive_idle(); drive_idle(); drive_idle();
    issue(mk(1, 32'h130, 1, 0, 32'h50, 32'h50, 8'h3C), mk(1, 32'h134, 0, 1, 32'h60, 32'h64, 8'hC3));
    drive_idle(); drive_idle();
    // Back-to-back mispredicts.
    issue(mk(1, 32'h140, 0, 1, 0, 0, 8'h01), nil);
    issue(mk(1, 32'h144, 1, 0, 0, 0, 8'h80), nil);
    drive_idle(); drive_idle();

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 5) == 0) drive_idle();
      else issue(rnd_slot(), rnd_slot());
    end
    repeat (12) drive_idle();

    // Fill with back-to-back dual retires to exercise backpressure.
    for (int i = 0; i < 14; i++)
      issue(mk(1, 32'h1000 + 8 * i, 1, 1, 32'h4, 32'h4, 8'(i)),
            mk(1, 32'h1004 + 8 * i, 0, 0, 32'h8, 32'h8, 8'(i + 64)));
    begin
      int guard = 0;
      while (fifo_cnt() != 5 && guard < 20) begin drive_idle(); guard++; end
      check("fill_to_5", fifo_cnt() == 5, 64'(fifo_cnt()), 5);
    end

    // Reset mid-drain.
    #1 reset = 1'b0;
    tq.delete(); rq.delete(); exp_rghr = '0;
    #1;
    check("midrst_train_valid", train_valid_o == 1'b0, 64'(train_valid_o), 0);
    check("midrst_ready", retire_ready_o == 1'b1, 64'(retire_ready_o), 1);
    check("midrst_recover_ghr", recover_ghr_snapshot_o == '0, 64'(recover_ghr_snapshot_o), 0);
    @(posedge clock); @(posedge clock); #1 reset = 1'b1;
    repeat (4) drive_idle();
    issue(mk(1, 32'h2000, 1, 1, 32'h20, 32'h20, 8'hA5), nil);
    repeat (4) drive_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/bp_train_unit.md
Name: bp_train_unit

Overview:
Retire-side companion to the branch predictor. Takes resolved branches from the ROB retire stage (up to RETIRE_W per cycle) and classifies each as correct or mispredicted. It buffers training records in an in-order FIFO and drains exactly one record per cycle onto the predictor's train port. On the oldest mispredict it issues a single-cycle recover pulse carrying the corrected global history.

Parameters:
GH, 8, global history bits; must match the predictor.
RETIRE_W, 2, retire slots per cycle; legal values are 1 or 2; slot 0 is oldest.
DEPTH, 8, training FIFO entries; power of two, DEPTH >= 2*RETIRE_W.

Ports:
clock  in  1  clock.
reset  in  1  asynchronous, active-low reset.
retire_valid_i  in  RETIRE_W  per slot: a retiring branch is present.
retire_pc_i  in  RETIRE_W*32  branch PC, slot k in bits [32k +: 32].
retire_actual_taken_i  in  RETIRE_W  resolved direction.
retire_actual_target_i  in  RETIRE_W*32  resolved target.
retire_pred_taken_i  in  RETIRE_W  direction predicted at fetch.
retire_pred_target_i  in  RETIRE_W*32  target predicted at fetch.
retire_ghr_snapshot_i  in  RETIRE_W*GH  history used at prediction.
retire_ready_o  out  1  FIFO can absorb RETIRE_W entries this cycle.
train_valid_o  out  1  training record valid.
train_pc_o  out  32  record PC.
train_actual_taken_o  out  1  record direction.
train_actual_target_o  out  32  record target.
train_ghr_snapshot_o  out  GH  record history.
recover_mispredict_pulse_o  out  1  single-cycle recovery strobe.
recover_ghr_snapshot_o  out  GH  corrected history.

Behaviour:
- Reset (reset==0, async):
  - FIFO empty; head, tail and count are 0.
  - All train_* outputs are 0; recover pulse is 0 and recover GHR is 0.
  - retire_ready_o is 1 while reset is deasserted-idle.
- Mispredict for slot k, when valid:
  - (pred_taken != actual_taken), or
  - (actual_taken && pred_taken && pred_target != actual_target).
- Accepted slots:
  - Slot 0 is accepted if it is valid.
  - Slot 1 is accepted only if it is valid and slot 0 is not a mispredict.
  - If slot 0 mispredicts, slot 1 is ignored entirely (no train, no recover).
- Enqueue:
  - Accepted slots are written in slot order at the tail on the clock edge.
  - This happens only when retire_ready_o == 1.
  - retire_ready_o = (DEPTH - count) >= RETIRE_W, a combinational function of count only.
  - Valid retires while ready == 0 are a protocol violation: entries are dropped and a simulation assertion fires.
- Dequeue:
  - The train_* outputs are driven directly from the FIFO head registers; train_valid_o = (count != 0).
  - The predictor always accepts, so the head pops on every edge where train_valid_o == 1.
  - Latency from retire to train_valid_o is 1 cycle minimum: enqueue on edge N, visible after edge N.
- Simultaneous events:
  - Enqueue and dequeue in the same cycle: count_next = count + n_enq - 1.
  - FIFO at full with a pop in that cycle: ready is still computed from the pre-pop count, so the policy stays conservative.
- Pointers wrap modulo DEPTH using log2(DEPTH)-bit pointers; count is log2(DEPTH)+1 bits.
- Recover:
  - On the oldest accepted mispredict slot m, the outputs are registered.
  - The cycle after the retire edge: recover_mispredict_pulse_o = 1 for exactly one cycle.
  - recover_ghr_snapshot_o = {retire_ghr_snapshot_i[m][GH-2:0], retire_actual_taken_i[m]}.
  - The recover GHR holds its value after the pulse and is not cleared.
  - The mispredicted branch is itself still enqueued for training.
- Back-to-back mispredicts on consecutive cycles give consecutive pulses, each with its own GHR.
- Reset asserted mid-operation: all state is cleared immediately and any in-flight pulse is aborted.

Optional Feature:
BP_TRAIN_PERF_EN:
- Defined: adds outputs perf_branch_count_o[31:0] and perf_mispredict_count_o[31:0].
  - They increment by the number of accepted slots and by accepted mispredicts per cycle.
  - Both wrap at 2^32 and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single correct branch:
  - Stimulus: slot 0 with pc=0x100, pred=actual taken, targets both 0x200, ghr=0x5A.
  - Response: next cycle train_valid=1 with pc 0x100 and target 0x200, recover pulse=0; count returns to 0.
- Direction mispredict:
  - Stimulus: slot 0 with pred_taken=0, actual_taken=1, ghr=0x81.
  - Response: 1 cycle later pulse=1 for one cycle with recover GHR=0x03; training record emitted.
- Target mispredict in slot 1:
  - Stimulus: both slots taken, slot 1 pred_target 0x40 vs actual 0x44, ghr1=0xFF.
  - Response: pulse with recover GHR=0xFF; two train records, in order, on consecutive cycles.
- Slot 0 mispredict with slot 1 valid:
  - Response: only the slot 0 record is trained; recover uses slot 0's GHR.
- Fill and backpressure (DEPTH=8):
  - Stimulus: drive 2 branches per cycle.
  - Response: ready drops at count 7 or 8; no drops; all 8+ records drain in PC order, one per cycle.
- Reset mid-drain:
  - Stimulus: assert reset with count=5.
  - Response: train_valid=0 and ready=1 immediately; no stale records after release.
